imm_decode_stage: RTL and testbench

- Pipelined immediate-decode stage between instruction fetch and the sign-extension/execute path of the RV32 core.
- Accepts one 32-bit RISC-V instruction per valid/ready transfer. Classifies the immediate format from the opcode, assembles the raw immediate field and sign-extends it to XLEN.
- Presents the result one cycle later on a registered valid/ready output.

---
 rtl/imm_decode_pkg.sv | 27 ++
 rtl/imm_field_extract.sv | 55 +++++
 rtl/imm_decode_stage.sv | 124 ++++++++++++
 tb/tb_imm_decode_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_decode_pkg.sv
// Shared types and opcode constants for the RV32 immediate-decode stage.
package imm_decode_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;

  // instr[1:0] value marking a 32-bit (non-compressed) encoding
  localparam logic [1:0] LEN_32BIT = 2'b11;

endpackage

// File: rtl/imm_field_extract.sv
// Combinational immediate classifier: opcode -> format, raw field assembly,
// sign extension to XLEN.
module imm_field_extract
  import imm_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output imm_fmt_e        fmt_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;

  always_comb begin
    fmt_o     = FMT_NONE;
    illegal_o = 1'b0;
    imm32     = '0;
    if (instr_i[1:0] != LEN_32BIT) begin
      illegal_o = 1'b1;
    end else begin
      case (instr_i[6:0])
        OP_IMM, LOAD, JALR, SYSTEM: begin
          fmt_o = FMT_I;
          imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
        end
        STORE: begin
          fmt_o = FMT_S;
          imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        end
        BRANCH: begin
          fmt_o = FMT_B;
          imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                   instr_i[30:25], instr_i[11:8], 1'b0};
        end
        LUI, AUIPC: begin
          fmt_o = FMT_U;
          imm32 = {instr_i[31:12], 12'b0};
        end
        JAL: begin
          fmt_o = FMT_J;
          imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                   instr_i[20], instr_i[30:21], 1'b0};
        end
        OP:      fmt_o = FMT_NONE;
        default: illegal_o = 1'b1;
      endcase
    end
  end

  // Every 32-bit immediate is already sign-correct; widening keeps bit 31 as sign.
  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// Registered valid/ready immediate-decode stage. Define IMM_DECODE_SKID_EN for a
// 2-entry skid buffer with flop-driven o_ready; otherwise a single output register.
module imm_decode_stage
  import imm_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_fmt,
  output logic            o_illegal
);

  if ((XLEN != 32) && (XLEN != 64)) begin : g_xlen_check
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic            illegal;
  } entry_t;

  imm_fmt_e        dec_fmt;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_imm;
  entry_t          dec_entry;

  imm_field_extract #(.XLEN(XLEN)) u_extract (
    .instr_i   (i_instr),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_illegal),
    .imm_o     (dec_imm)
  );

  assign dec_entry = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal};

  entry_t main_q, main_d;
  logic   main_vld_q, main_vld_d;
  logic   in_fire, out_fire;

  assign in_fire  = i_valid & o_ready;
  assign out_fire = main_vld_q & i_ready;

`ifdef IMM_DECODE_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_vld_q, skid_vld_d;

  assign o_ready = ~skid_vld_q;

  // Skid is only ever occupied while main is, so a free main slot means skid is empty
  // or draining; when skid holds data o_ready is low and no input can arrive.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (i_flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || out_fire) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = in_fire;
        if (in_fire) main_d = dec_entry;
      end
    end else if (in_fire) begin
      skid_d     = dec_entry;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end
`else
  assign o_ready = ~main_vld_q | i_ready;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    if (i_flush) begin
      main_vld_d = 1'b0;
    end else if (in_fire) begin
      main_d     = dec_entry;
      main_vld_d = 1'b1;
    end else if (out_fire) begin
      main_vld_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
    end
  end

  assign o_valid   = main_vld_q;
  assign o_imm     = main_q.imm;
  assign o_fmt     = main_q.fmt;
  assign o_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: XLEN=32 and XLEN=64 instances share
// stimulus; a queue-based reference model predicts handshake and decoded values.
module tb_imm_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, valid, ready;
  logic [31:0] instr;

  logic        o_ready, o_valid, o_illegal;
  logic [31:0] o_imm;
  logic [2:0]  o_fmt;
  logic        o_ready64, o_valid64, o_illegal64;
  logic [63:0] o_imm64;
  logic [2:0]  o_fmt64;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] q[$];

  imm_decode_stage #(.XLEN(32)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(o_ready),
    .i_instr(instr), .o_valid(o_valid), .i_ready(ready), .o_imm(o_imm), .o_fmt(o_fmt),
    .o_illegal(o_illegal)
  );

  imm_decode_stage #(.XLEN(64)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(o_ready64),
    .i_instr(instr), .o_valid(o_valid64), .i_ready(ready), .o_imm(o_imm64), .o_fmt(o_fmt64),
    .o_illegal(o_illegal64)
  );

  // Reference: raw field value and width, then two's-complement interpretation.
  function automatic void ref_decode(input logic [31:0] in, output logic [2:0] fmt,
                                     output logic ill, output logic [63:0] imm);
    longint unsigned raw;
    int              nbits;
    longint          v;
    fmt = 3'd0; ill = 1'b0; raw = 0; nbits = 0;
    case (in[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: begin fmt = 3'd1; raw = in[31:20]; nbits = 12; end
      7'h23: begin fmt = 3'd2; raw = {in[31:25], in[11:7]}; nbits = 12; end
      7'h63: begin fmt = 3'd3; raw = {in[31], in[7], in[30:25], in[11:8], 1'b0}; nbits = 13; end
      7'h37, 7'h17: begin fmt = 3'd4; raw = {in[31:12], 12'h000}; nbits = 32; end
      7'h6F: begin fmt = 3'd5; raw = {in[31], in[19:12], in[20], in[30:21], 1'b0}; nbits = 21; end
      7'h33: fmt = 3'd0;
      default: ill = 1'b1;
    endcase
    v = longint'(raw);
    if (nbits > 0 && raw >= (64'd1 << (nbits - 1))) v = v - longint'(64'd1 << nbits);
    imm = v;
  endfunction

  task automatic cycle(input logic v, input logic [31:0] ins, input logic r,
                       input logic f, input logic rst, output logic acc);
    logic        exp_rdy, exp_v, in_fire, out_fire, ei;
    logic [2:0]  ef;
    logic [63:0] eimm;
    valid = v; instr = ins; ready = r; flush = f; rst_n = ~rst;
    #3;
    exp_v = (q.size() > 0);
`ifdef IMM_DECODE_SKID_EN
    exp_rdy = (q.size() < 2);
`else
    exp_rdy = (q.size() == 0) || r;
`endif
    vectors++;
    if (o_ready !== exp_rdy) begin errors++; $display("FAIL o_ready: got %b exp %b", o_ready, exp_rdy); end
    vectors++;
    if (o_ready64 !== exp_rdy) begin errors++; $display("FAIL o_ready64: got %b exp %b", o_ready64, exp_rdy); end
    vectors++;
    if (o_valid !== exp_v) begin errors++; $display("FAIL o_valid: got %b exp %b", o_valid, exp_v); end
    vectors++;
    if (o_valid64 !== exp_v) begin errors++; $display("FAIL o_valid64: got %b exp %b", o_valid64, exp_v); end
    if (exp_v) begin
      ref_decode(q[0], ef, ei, eimm);
      vectors++;
      if (o_imm !== eimm[31:0]) begin errors++; $display("FAIL o_imm instr=%h: got %h exp %h", q[0], o_imm, eimm[31:0]); end
      vectors++;
      if (o_imm64 !== eimm) begin errors++; $display("FAIL o_imm64 instr=%h: got %h exp %h", q[0], o_imm64, eimm); end
      vectors++;
      if (o_fmt !== ef || o_fmt64 !== ef) begin errors++; $display("FAIL o_fmt instr=%h: got %0d/%0d exp %0d", q[0], o_fmt, o_fmt64, ef); end
      vectors++;
      if (o_illegal !== ei || o_illegal64 !== ei) begin errors++; $display("FAIL o_illegal instr=%h: got %b/%b exp %b", q[0], o_illegal, o_illegal64, ei); end
    end
    in_fire  = v & exp_rdy;
    out_fire = exp_v & r;
    acc      = in_fire & ~f & ~rst;
    @(posedge clk);
    if (rst || f) q.delete();
    else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire) q.push_back(ins);
    end
    #1;
  endtask

  task automatic test_reset();
    logic acc;
    cycle(1'b1, 32'h00100093, 1'b0, 1'b0, 1'b1, acc);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    vectors++;
    if (o_valid !== 1'b0 || o_imm !== 32'h0 || o_fmt !== 3'd0 || o_illegal !== 1'b0 || o_imm64 !== 64'h0) begin
      errors++; $display("FAIL reset_outputs: got v=%b imm=%h fmt=%0d ill=%b exp all 0", o_valid, o_imm, o_fmt, o_illegal);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
  endtask

  task automatic test_i_format();
    logic acc;
    cycle(1'b1, 32'hFFF00093, 1'b1, 1'b0, 1'b0, acc);
    vectors++;
    if (o_valid !== 1'b1 || o_fmt !== 3'd1 || o_imm !== 32'hFFFFFFFF || o_illegal !== 1'b0) begin
      errors++; $display("FAIL i_format: got v=%b fmt=%0d imm=%h ill=%b exp 1/1/ffffffff/0", o_valid, o_fmt, o_imm, o_illegal);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins[3]  = '{32'hFE112E23, 32'h00000463, 32'h123450B7};
    logic [2:0]  fmts[3] = '{3'd2, 3'd3, 3'd4};
    logic [31:0] imms[3] = '{32'hFFFFFFFC, 32'h00000008, 32'h12345000};
    logic acc;
    for (int i = 0; i < 4; i++) begin
      cycle(i < 3, (i < 3) ? ins[i] : 32'h0, 1'b1, 1'b0, 1'b0, acc);
      if (i < 3) begin
        vectors++;
        if (o_valid !== 1'b1 || o_fmt !== fmts[i] || o_imm !== imms[i]) begin
          errors++; $display("FAIL b2b[%0d]: got v=%b fmt=%0d imm=%h exp 1/%0d/%h", i, o_valid, o_fmt, o_imm, fmts[i], imms[i]);
        end
      end
    end
  endtask

  task automatic test_j_xlen64();
    logic acc;
    cycle(1'b1, 32'hFF9FF06F, 1'b1, 1'b0, 1'b0, acc);
    vectors++;
    if (o_fmt !== 3'd5 || o_imm !== 32'hFFFFFFF8 || o_imm64 !== 64'hFFFFFFFFFFFFFFF8) begin
      errors++; $display("FAIL j_format: got fmt=%0d imm=%h imm64=%h exp 5/fffffff8/fffffffffffffff8", o_fmt, o_imm, o_imm64);
    end
    cycle(1'b1, 32'h800000B7, 1'b1, 1'b0, 1'b0, acc);
    vectors++;
    if (o_imm64 !== 64'hFFFFFFFF80000000 || o_imm !== 32'h80000000) begin
      errors++; $display("FAIL u_xlen64: got imm64=%h imm=%h exp ffffffff80000000/80000000", o_imm64, o_imm);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
  endtask

  task automatic test_backpressure();
    logic [31:0] ins[3] = '{32'h00100093, 32'h00200093, 32'h00300093};
    int idx = 0;
    int n   = 0;
    logic acc;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1, ins[idx], 1'b0, 1'b0, 1'b0, acc);
      if (acc) idx++;
      vectors++;
      if (o_valid !== 1'b1 || o_imm !== 32'h1) begin
        errors++; $display("FAIL stall_hold[%0d]: got v=%b imm=%h exp 1/00000001", c, o_valid, o_imm);
      end
    end
    vectors++;
    if (o_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b exp 0", o_ready); end
    while ((idx < 3 || q.size() > 0) && n < 20) begin
      cycle(idx < 3, (idx < 3) ? ins[idx] : 32'h0, 1'b1, 1'b0, 1'b0, acc);
      if (acc) idx++;
      n++;
    end
    vectors++;
    if (n >= 20) begin errors++; $display("FAIL drain_timeout: got %0d cycles exp <20", n); end
  endtask

  task automatic test_illegal_flush();
    logic acc;
    cycle(1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, acc);
    vectors++;
    if (o_valid !== 1'b1 || o_illegal !== 1'b1 || o_fmt !== 3'd0 || o_imm !== 32'h0) begin
      errors++; $display("FAIL illegal: got v=%b ill=%b fmt=%0d imm=%h exp 1/1/0/0", o_valid, o_illegal, o_fmt, o_imm);
    end
    cycle(1'b1, 32'h00700093, 1'b1, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h00800093, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h00900013, 1'b0, 1'b1, 1'b0, acc);
    vectors++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", o_valid); end
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
    vectors++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_absent: got %b exp 0", o_valid); end
  endtask

  task automatic test_reset_midstream();
    logic acc;
    cycle(1'b1, 32'h00A00093, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h00B00093, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h00C00093, 1'b0, 1'b0, 1'b1, acc);
    vectors++;
    if (o_valid !== 1'b0 || o_imm !== 32'h0 || o_fmt !== 3'd0 || o_illegal !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL midreset: got v=%b imm=%h fmt=%0d ill=%b rdy=%b exp 0/0/0/0/1", o_valid, o_imm, o_fmt, o_illegal, o_ready);
    end
    cycle(1'b1, 32'h00500093, 1'b1, 1'b0, 1'b0, acc);
    vectors++;
    if (o_valid !== 1'b1 || o_imm !== 32'h5 || o_fmt !== 3'd1) begin
      errors++; $display("FAIL post_reset: got v=%b imm=%h fmt=%0d exp 1/00000005/1", o_valid, o_imm, o_fmt);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
  endtask

  task automatic test_random();
    logic [6:0] opcs[11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};
    logic [31:0] w;
    logic acc;
    for (int c = 0; c < 600; c++) begin
      w = $urandom;
      if ($urandom_range(0, 7) != 0) w[6:0] = opcs[$urandom_range(0, 9)];
      cycle($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0,
            $urandom_range(0, 31) == 0, $urandom_range(0, 99) == 0, acc);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; valid = 1'b0; ready = 1'b0; instr = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_i_format();
    test_back_to_back();
    test_j_xlen64();
    test_backpressure();
    test_illegal_flush();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
